// File: rtl/gru_matvec_sched.sv
// gru_matvec_sched: sequences a 4-lane dot-product unit over ROWS x COLS/4 chunks to form y = W*x.
//   start          in   begin a pass (sampled in IDLE only)
//   busy/done/err  out  not-idle / pass-complete pulse / WAIT-timeout pulse
//   w_addr/x_addr  out  weight and vector word addresses, valid from FETCH
//   mac_en         out  one-cycle operand-valid strobe to the dot-product unit
//   mac_valid/sum  in   dot-product result handshake
//   out_valid/row/data  out  one-cycle pulse with the saturated row result
module gru_matvec_sched #(
    parameter int ROWS    = 16,
    parameter int COLS    = 16,
    parameter int TIMEOUT = 64,
    localparam int CHUNKS = COLS / 4,
    localparam int AW     = (ROWS * CHUNKS > 1) ? $clog2(ROWS * CHUNKS) : 1,
    localparam int XW     = (CHUNKS > 1) ? $clog2(CHUNKS) : 1,
    localparam int RW     = (ROWS > 1) ? $clog2(ROWS) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic [AW-1:0]        w_addr,
    output logic [XW-1:0]        x_addr,
    output logic                 mac_en,
    input  logic                 mac_valid,
    input  logic signed [15:0]   mac_sum,
    output logic                 out_valid,
    output logic [RW-1:0]        out_row,
    output logic signed [15:0]   out_data
);
    localparam int CW = $clog2(TIMEOUT);

    typedef enum logic [2:0] {IDLE, FETCH, ISSUE, WAIT, WRITE} state_t;

    state_t             state_q, state_d;
    logic [RW-1:0]      row_q, row_d, out_row_q, out_row_d;
    logic [XW-1:0]      chunk_q, chunk_d, x_addr_q, x_addr_d;
    logic [AW-1:0]      w_addr_q, w_addr_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic signed [23:0] acc_q, acc_d;
    logic signed [15:0] out_data_q, out_data_d;
    logic               done_q, done_d, err_q, err_d, mac_en_q, mac_en_d, out_valid_q, out_valid_d;

    function automatic logic signed [15:0] sat16(input logic signed [23:0] a);
        return (a > 24'sd32767) ? 16'sh7fff : (a < -24'sd32768) ? 16'sh8000 : a[15:0];
    endfunction

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        chunk_d = chunk_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            IDLE: if (start) begin
                row_d   = '0;
                chunk_d = '0;
                acc_d   = '0;
                state_d = FETCH;
            end
            FETCH: state_d = ISSUE;
            ISSUE: begin
                cnt_d   = '0;
                state_d = WAIT;
            end
            WAIT: if (mac_valid) begin
                acc_d   = acc_q + {{8{mac_sum[15]}}, mac_sum};
                chunk_d = (chunk_q == XW'(CHUNKS - 1)) ? chunk_q : chunk_q + XW'(1);
                state_d = (chunk_q == XW'(CHUNKS - 1)) ? WRITE : FETCH;
            end else if (cnt_q == CW'(TIMEOUT - 2)) begin
                // cnt counts WAIT cycles from zero, so err lands TIMEOUT cycles after mac_en
                err_d   = 1'b1;
                state_d = IDLE;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
            WRITE: begin
                acc_d   = '0;
                chunk_d = '0;
                done_d  = (row_q == RW'(ROWS - 1));
                row_d   = (row_q == RW'(ROWS - 1)) ? row_q : row_q + RW'(1);
                state_d = (row_q == RW'(ROWS - 1)) ? IDLE : FETCH;
            end
            default: state_d = IDLE;
        endcase
        // Outputs are registered from the next state so they are valid in the state itself
        mac_en_d    = (state_d == ISSUE);
        out_valid_d = (state_d == WRITE);
        w_addr_d    = (state_d == FETCH) ? AW'(row_d) * AW'(CHUNKS) + AW'(chunk_d) : w_addr_q;
        x_addr_d    = (state_d == FETCH) ? chunk_d : x_addr_q;
        out_row_d   = out_valid_d ? row_d : out_row_q;
        out_data_d  = out_valid_d ? sat16(acc_d) : out_data_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            row_q       <= '0;
            chunk_q     <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            mac_en_q    <= 1'b0;
            out_valid_q <= 1'b0;
            w_addr_q    <= '0;
            x_addr_q    <= '0;
            out_row_q   <= '0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            chunk_q     <= chunk_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            done_q      <= done_d;
            err_q       <= err_d;
            mac_en_q    <= mac_en_d;
            out_valid_q <= out_valid_d;
            w_addr_q    <= w_addr_d;
            x_addr_q    <= x_addr_d;
            out_row_q   <= out_row_d;
            out_data_q  <= out_data_d;
        end
    end

    assign busy      = (state_q != IDLE);
    assign done      = done_q;
    assign err       = err_q;
    assign mac_en    = mac_en_q;
    assign out_valid = out_valid_q;
    assign w_addr    = w_addr_q;
    assign x_addr    = x_addr_q;
    assign out_row   = out_row_q;
    assign out_data  = out_data_q;
endmodule

// File: tb/tb_gru_matvec_sched.sv
// tb_gru_matvec_sched: randomized and directed passes checked against a row-sum/saturation model.
module tb_gru_matvec_sched;
    localparam int ROWS = 2, COLS = 8, CH = COLS / 4, TO = 64, N = ROWS * CH;

    logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, mac_valid = 1'b0;
    logic signed [15:0] mac_sum = '0;
    logic busy, done, err, mac_en, out_valid;
    logic [1:0] w_addr;
    logic [0:0] x_addr, out_row;
    logic signed [15:0] out_data;

    gru_matvec_sched #(.ROWS(ROWS), .COLS(COLS), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done), .err(err),
        .w_addr(w_addr), .x_addr(x_addr), .mac_en(mac_en), .mac_valid(mac_valid),
        .mac_sum(mac_sum), .out_valid(out_valid), .out_row(out_row), .out_data(out_data)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_fail = 0;

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int sat(input int v);
        return (v > 32767) ? 32767 : (v < -32768) ? -32768 : v;
    endfunction

    // dot-product unit model: answers each mac_en after resp_lat cycles with the next queued sum
    int resp_lat = 1;
    bit resp_on = 1'b1, resp_spur = 1'b0;
    int sums[$];

    initial forever begin
        @(posedge clk);
        #1;
        while (mac_en && resp_on && rst_n) begin
            repeat (resp_lat) @(posedge clk);
            #1 mac_valid = 1'b1;
            mac_sum = (sums.size() > 0) ? 16'(sums.pop_front()) : 16'sd0;
            @(posedge clk);
            #1;
            if (resp_spur) begin
                // valid left high into FETCH/WRITE with a junk value that must be ignored
                mac_sum = 16'sd5000;
                @(posedge clk);
                #1;
            end
            mac_valid = 1'b0;
        end
    end

    int cyc = 0, n_en = 0, n_done = 0, n_err = 0, t_done = 0, t_err = 0, t_en = 0;
    int q_w[$], q_x[$], q_row[$], q_dat[$];

    initial forever begin
        @(posedge clk);
        cyc++;
        #1;
        if (mac_en) begin
            if (n_en == 0) t_en = cyc;
            n_en++;
            q_w.push_back(int'(w_addr));
            q_x.push_back(int'(x_addr));
        end
        if (out_valid) begin
            q_row.push_back(int'(out_row));
            q_dat.push_back(int'(out_data));
        end
        if (done) begin
            n_done++;
            t_done = cyc;
        end
        if (err) begin
            n_err++;
            t_err = cyc;
        end
    end

    task automatic clr_mon();
        n_en = 0; n_done = 0; n_err = 0;
        q_w.delete(); q_x.delete(); q_row.delete(); q_dat.delete();
    endtask

    task automatic run_pass(input string tag, input int lat, input int s[N], input bit spur, input bit hold);
        int t0, exp_t;
        clr_mon();
        sums.delete();
        foreach (s[k]) sums.push_back(s[k]);
        resp_lat = lat; resp_on = 1'b1; resp_spur = spur;
        mac_valid = 1'b1; mac_sum = 16'sd12345;
        @(posedge clk);
        #2 mac_valid = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #2 t0 = cyc;
        chk({tag, " busy"}, busy, 1);
        if (!hold) start = 1'b0;
        for (int i = 0; i < 2000 && n_done == 0 && n_err == 0; i++) begin
            @(posedge clk);
            #2;
            if (!hold && i == 7) start = 1'b1;
            if (!hold && i == 8) start = 1'b0;
            if (n_done > 0) start = 1'b0;
        end
        start = 1'b0;
        exp_t = ROWS * (CH * (2 + lat) + 1) + 1;
        chk({tag, " done"}, n_done, 1);
        chk({tag, " err"}, n_err, 0);
        chk({tag, " done_time"}, t_done - t0 + 1, exp_t);
        chk({tag, " mac_en_cnt"}, n_en, N);
        for (int k = 0; k < N && k < q_w.size(); k++) begin
            chk($sformatf("%s w_addr%0d", tag, k), q_w[k], k);
            chk($sformatf("%s x_addr%0d", tag, k), q_x[k], k % CH);
        end
        chk({tag, " rows"}, q_row.size(), ROWS);
        for (int r = 0; r < ROWS && r < q_row.size(); r++) begin
            int acc = 0;
            for (int c = 0; c < CH; c++) acc += s[r * CH + c];
            chk($sformatf("%s row%0d", tag, r), q_row[r], r);
            chk($sformatf("%s data%0d", tag, r), q_dat[r], sat(acc));
        end
        repeat (10) @(posedge clk);
        #2;
        chk({tag, " single_done"}, n_done, 1);
        chk({tag, " idle"}, busy, 0);
    endtask

    initial begin
        int s[N];
        repeat (3) @(posedge clk);
        #2;
        chk("rst busy", busy, 0);
        chk("rst done", done, 0);
        chk("rst err", err, 0);
        chk("rst mac_en", mac_en, 0);
        chk("rst out_valid", out_valid, 0);
        chk("rst w_addr", w_addr, 0);
        chk("rst out_data", out_data, 0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #2;

        run_pass("basic", 4, '{100, 100, 100, 100}, 1'b0, 1'b0);
        run_pass("sat", 2, '{30000, 30000, -30000, -30000}, 1'b0, 1'b0);
        run_pass("noclamp", 3, '{30000, -30000, -32768, -32768}, 1'b0, 1'b0);
        run_pass("hold", 2, '{-7, 1234, 500, -20000}, 1'b1, 1'b1);
        run_pass("lat1", 1, '{1, 2, 3, 4}, 1'b0, 1'b0);

        // no response from the dot-product unit: pass must abort with err
        clr_mon();
        resp_on = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #2 start = 1'b0;
        for (int i = 0; i < 300 && n_err == 0; i++) begin
            @(posedge clk);
            #2;
        end
        chk("to err", n_err, 1);
        chk("to err_time", t_err - t_en, TO);
        chk("to busy", busy, 0);
        chk("to done", n_done, 0);
        chk("to out", q_row.size(), 0);
        repeat (5) @(posedge clk);
        #2;
        run_pass("after_to", 2, '{10, 20, 30, 40}, 1'b0, 1'b0);

        // asynchronous reset in the WAIT of row 1
        clr_mon();
        sums.delete();
        foreach (s[k]) begin
            s[k] = 1000;
            sums.push_back(s[k]);
        end
        resp_lat = 8; resp_on = 1'b1; resp_spur = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #2 start = 1'b0;
        for (int i = 0; i < 300 && n_en < 3; i++) begin
            @(posedge clk);
            #2;
        end
        chk("rw row0", (q_dat.size() > 0) ? q_dat[0] : -1, 2000);
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("rw busy", busy, 0);
        chk("rw mac_en", mac_en, 0);
        chk("rw out_valid", out_valid, 0);
        chk("rw w_addr", w_addr, 0);
        chk("rw x_addr", x_addr, 0);
        chk("rw out_row", out_row, 0);
        chk("rw out_data", out_data, 0);
        chk("rw done", done, 0);
        chk("rw err", err, 0);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (20) @(posedge clk);
        #2;
        chk("rw idle", busy, 0);
        chk("rw no_mac_en", n_en, 3);
        chk("rw no_done", n_done + n_err, 0);
        chk("rw outs", q_row.size(), 1);
        run_pass("after_rst", 3, '{5, 6, 7, 8}, 1'b0, 1'b0);

        for (int it = 0; it < 6; it++) begin
            foreach (s[k]) s[k] = int'($signed(16'($urandom)));
            run_pass($sformatf("rnd%0d", it), int'($urandom_range(1, 6)), s, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule
